// File: rtl/core_pkg.sv
// Core-wide physical register parameters and tag types, shared by rename,
// ROB, issue queue and the free list.
package core_pkg;

    localparam int NPREG = 64;
    localparam int NARCH = 32;
    localparam int PW    = $clog2(NPREG);

    typedef logic [PW-1:0] preg_t;
    typedef logic [PW:0]   count_t;

    localparam count_t RESET_COUNT = count_t'(NPREG - NARCH);
    localparam count_t MAX_COUNT   = count_t'(NPREG - 1);
    localparam preg_t  RESET_TAIL  = preg_t'(NPREG - NARCH);

    // Tags at or above NARCH start out free; the architectural ones are mapped.
    function automatic logic [NPREG-1:0] reset_pool_mask();
        logic [NPREG-1:0] mask;
        mask = '0;
        for (int t = NARCH; t < NPREG; t++) begin
            mask[t] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Allocate/release handshake between rename + ROB retirement and the
// physical register free list.
interface phys_reg_free_list_if;
    import core_pkg::*;

    logic   alloc_take;
    logic   alloc_valid;
    preg_t  alloc_preg;
    logic   rel_en_0;
    preg_t  rel_preg_0;
    logic   rel_en_1;
    preg_t  rel_preg_1;
    count_t free_count;
    logic   stall;
    logic   dbl_free_err;

    modport master (
        output alloc_take, rel_en_0, rel_preg_0, rel_en_1, rel_preg_1,
        input  alloc_valid, alloc_preg, free_count, stall, dbl_free_err
    );

    modport slave (
        input  alloc_take, rel_en_0, rel_preg_0, rel_en_1, rel_preg_1,
        output alloc_valid, alloc_preg, free_count, stall, dbl_free_err
    );

endinterface

// File: rtl/free_list_fifo.sv
// Circular tag buffer: one read at the head, up to two compacted writes at
// the tail per cycle, with an occupancy count.
module free_list_fifo
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   rd_en,
    input  logic   wr_en_0,
    input  preg_t  wr_data_0,
    input  logic   wr_en_1,
    input  preg_t  wr_data_1,
    output preg_t  rd_data,
    output count_t count
);

    preg_t  mem [NPREG];
    preg_t  head;
    preg_t  tail;
    preg_t  wr_idx_1;
    count_t n_written;

    // Slot 1 lands right behind slot 0 only when slot 0 actually wrote.
    assign wr_idx_1  = wr_en_0 ? tail + preg_t'(1) : tail;
    assign n_written = count_t'(wr_en_0) + count_t'(wr_en_1);
    assign rd_data   = mem[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPREG; i++) begin
                mem[i] <= (i < NPREG - NARCH) ? preg_t'(i + NARCH) : '0;
            end
            head  <= '0;
            tail  <= RESET_TAIL;
            count <= RESET_COUNT;
        end else begin
            if (wr_en_0) mem[tail] <= wr_data_0;
            if (wr_en_1) mem[wr_idx_1] <= wr_data_1;
            if (rd_en) head <= head + preg_t'(1);
            tail  <= tail + preg_t'(n_written);
            count <= count - count_t'(rd_en) + n_written;
        end
    end

    // p0 never enters the pool, so the buffer can never hold NPREG tags.
    assert property (@(posedge clk) disable iff (rst) count <= MAX_COUNT);

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: hands fresh tags to rename and reclaims up to
// two retired tags per cycle, filtering double-frees through an in-pool bitmap.
module phys_reg_free_list
    import core_pkg::*;
(
    input logic clk,
    input logic rst,
    phys_reg_free_list_if.slave fl
);

    logic [NPREG-1:0] in_pool;
    logic [NPREG-1:0] in_pool_eff;
    logic   take;
    logic   acc_0;
    logic   acc_1;
    logic   rej_0;
    logic   rej_1;
    logic   err;
    preg_t  head_tag;
    count_t count;

    // A tag taken this cycle is already out of the pool, so releasing it in
    // the same cycle is legal and re-appends it at the tail.
    always_comb begin
        take        = fl.alloc_take && (count != '0);
        in_pool_eff = in_pool;
        if (take) in_pool_eff[head_tag] = 1'b0;

        acc_0 = fl.rel_en_0 && (fl.rel_preg_0 != '0) && !in_pool_eff[fl.rel_preg_0];
        acc_1 = fl.rel_en_1 && (fl.rel_preg_1 != '0) && !in_pool_eff[fl.rel_preg_1]
                && !(fl.rel_en_0 && (fl.rel_preg_1 == fl.rel_preg_0));
        rej_0 = fl.rel_en_0 && (fl.rel_preg_0 != '0) && !acc_0;
        rej_1 = fl.rel_en_1 && (fl.rel_preg_1 != '0) && !acc_1;
    end

    free_list_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (take),
        .wr_en_0   (acc_0),
        .wr_data_0 (fl.rel_preg_0),
        .wr_en_1   (acc_1),
        .wr_data_1 (fl.rel_preg_1),
        .rd_data   (head_tag),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pool <= reset_pool_mask();
            err     <= 1'b0;
        end else begin
            in_pool <= in_pool_eff
                     | (NPREG'(acc_0) << fl.rel_preg_0)
                     | (NPREG'(acc_1) << fl.rel_preg_1);
            err     <= err | rej_0 | rej_1;
        end
    end

    assign fl.alloc_valid  = (count != '0);
    assign fl.alloc_preg   = head_tag;
    assign fl.free_count   = count;
    assign fl.stall        = (count == '0);
    assign fl.dbl_free_err = err;

endmodule
